rr_onehot_arbiter: RTL and testbench

//  Round-robin arbiter over M requesters; upstream stage of the one-hot -> binary encoder.

---
 rtl/rr_onehot_arbiter_pkg.sv | 9 +
 rtl/rr_onehot_arbiter_encodernbit.sv | 21 ++
 rtl/rr_onehot_arbiter.sv | 103 ++++++++++
 tb/tb_rr_onehot_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rr_onehot_arbiter_pkg.sv
// rtl/rr_onehot_arbiter_pkg.sv - shared state encodings for the round-robin arbiter
package rr_onehot_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_onehot_arbiter_encodernbit.sv
// rtl/rr_onehot_arbiter_encodernbit.sv - one-hot to binary encoder (zero input gives zero index)
module encodernbit #(
   parameter int N = 2
) (
   input  logic [(2**N)-1:0] i_onehot,
   output logic [N-1:0]      o_idx
);

   // Each index bit is the OR of every one-hot position whose index has that bit set.
   always_comb begin
      o_idx = '0;
      for (int p = 0; p < 2**N; p++) begin
         for (int b = 0; b < N; b++) begin
            if (((p >> b) & 1) == 1) begin
               o_idx[b] = o_idx[b] | i_onehot[p];
            end
         end
      end
   end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - round-robin arbiter with registered one-hot grant and valid/ready handshake
module rr_onehot_arbiter
   import rr_onehot_arbiter_pkg::*;
#(
   parameter int N = 2,
   parameter int M = 2**N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [M-1:0] req,
   input  logic         grant_ready,
   output logic [M-1:0] grant,
   output logic [N-1:0] grant_idx,
   output logic         grant_valid
);

   arb_state_t   r_state;
   arb_state_t   w_state_nxt;
   logic [M-1:0] r_grant;
   logic [M-1:0] w_grant_nxt;
   logic [N-1:0] r_ptr;
   logic [N-1:0] w_ptr_nxt;
   logic [N-1:0] w_idx;
   logic         w_accept;
   logic [N-1:0] w_search_ptr;
   logic [2*M-1:0] w_dbl;
   logic [M-1:0] w_rot;
   logic         w_found;
   logic [N-1:0] w_win_idx;
   logic [M-1:0] w_win;

   encodernbit #(.N(N)) u_enc (
      .i_onehot (r_grant),
      .o_idx    (w_idx)
   );

   assign w_accept     = (r_state == ARB_GRANT) && grant_ready;
   // On accept the search already starts one past the winner being retired.
   assign w_search_ptr = w_accept ? (w_idx + N'(1)) : r_ptr;

   always_comb begin
      w_dbl     = {req, req};
      w_rot     = w_dbl[w_search_ptr +: M];
      w_found   = 1'b0;
      w_win_idx = '0;
      w_win     = '0;
      for (int j = 0; j < M; j++) begin
         if (!w_found && w_rot[j]) begin
            w_found   = 1'b1;
            w_win_idx = w_search_ptr + N'(j);
         end
      end
      if (w_found) begin
         w_win[w_win_idx] = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         ARB_IDLE: begin
            if (w_found) begin
               w_grant_nxt = w_win;
               w_state_nxt = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (w_accept) begin
               w_ptr_nxt = w_search_ptr;
               if (w_found) begin
                  w_grant_nxt = w_win;
               end else begin
                  w_grant_nxt = '0;
                  w_state_nxt = ARB_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_idx   = w_idx;
   assign grant_valid = (r_state == ARB_GRANT);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - directed self-checking bench for rr_onehot_arbiter (N=2, M=4)
module tb_rr_onehot_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       grant_ready;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;

   int n_tests;
   int n_fail;

   rr_onehot_arbiter #(.N(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant_ready (grant_ready),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic v);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".idx"},   32'(grant_idx), 32'(idx));
      check({tag, ".valid"}, 32'(grant_valid), 32'(v));
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      req         = 4'b1111;
      grant_ready = 1'b0;

      // 1: reset holds outputs at zero despite requests
      step();
      step();
      check_out("reset", 4'b0000, 2'd0, 1'b0);

      // 2: single grant held while not ready, then retired
      rst_n = 1'b1;
      req   = 4'b0100;
      step();
      check_out("t2_first", 4'b0100, 2'd2, 1'b1);
      req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         step();
         check_out($sformatf("t2_hold%0d", i), 4'b0100, 2'd2, 1'b1);
      end
      grant_ready = 1'b1;
      step();
      check_out("t2_accept", 4'b0000, 2'd0, 1'b0);
      step();
      check_out("t2_ready_idle", 4'b0000, 2'd0, 1'b0);

      // 4: ptr=3 searches 3,0,... so req 0011 picks 0, then 1
      grant_ready = 1'b0;
      req         = 4'b0011;
      step();
      check_out("t4_first", 4'b0001, 2'd0, 1'b1);
      grant_ready = 1'b1;
      step();
      check_out("t4_second", 4'b0010, 2'd1, 1'b1);
      req = 4'b0000;
      step();
      check_out("t4_drain", 4'b0000, 2'd0, 1'b0);

      // 3: fairness after a fresh reset, grant every cycle
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req   = 4'b1111;
      step();
      check_out("t3_0", 4'b0001, 2'd0, 1'b1);
      step();
      check_out("t3_1", 4'b0010, 2'd1, 1'b1);
      step();
      check_out("t3_2", 4'b0100, 2'd2, 1'b1);
      step();
      check_out("t3_3", 4'b1000, 2'd3, 1'b1);
      step();
      check_out("t3_4", 4'b0001, 2'd0, 1'b1);

      // 5: sole requester re-granted with no bubble
      req = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         step();
         check_out($sformatf("t5_%0d", i), 4'b1000, 2'd3, 1'b1);
      end

      // 6: reset mid-grant drops it and clears ptr
      req = 4'b0010;
      step();
      check_out("t6_pre", 4'b0010, 2'd1, 1'b1);
      rst_n = 1'b0;
      step();
      check_out("t6_reset", 4'b0000, 2'd0, 1'b0);
      rst_n       = 1'b1;
      grant_ready = 1'b0;
      req         = 4'b1010;
      step();
      check_out("t6_after", 4'b0010, 2'd1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
